// File: rtl/uart_transmitter.sv
// UART 16750 serial transmit engine.
// Serialises one character per frame: start bit, 5-8 data bits LSB first, optional parity,
// then 1, 1.5 or 2 stop bits. Bit timing comes from the 16x baud enable on TXCLK.
//
// Ports:
//   CLK         system clock
//   RST         synchronous, active-high reset
//   TXCLK       baud enable pulse, OVERSAMPLE pulses per serial bit, one CLK wide
//   TXSTART     character available; accepted only while idle
//   CLEAR       synchronous abort, same effect as RST
//   WLS         word length select: 00=5, 01=6, 10=7, 11=8 bits
//   STB         stop bits: 0=1; 1=1.5 for 5-bit words, else 2
//   PEN         parity enable
//   EPS         even parity select
//   SP          stick parity
//   BC          break control, forces SOUT low while set
//   DIN         character to send; bits above the word length are ignored
//   TXFINISHED  high while idle and ready for a new character
//   SOUT        registered serial output, idle high
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TXCLK,
  input  logic       TXSTART,
  input  logic       CLEAR,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  input  logic [7:0] DIN,
  output logic       TXFINISHED,
  output logic       SOUT
);

  // Wide enough for the longest bit period (two stop bits held in one STOP state).
  localparam int unsigned TickW = $clog2(2 * OVERSAMPLE);
  localparam logic [TickW-1:0] LastOne     = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] LastOneHalf = TickW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [TickW-1:0] LastTwo     = TickW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       wls_q, wls_d;
  logic             stb_q, stb_d;
  logic             pen_q, pen_d;
  logic             eps_q, eps_d;
  logic             sp_q, sp_d;
  logic             sout_q, sout_d;
  logic             fin_q, fin_d;

  logic [TickW-1:0] tick_last;
  logic [2:0]       last_bit;
  logic [7:0]       mask_d;
  logic             parity_d;
  logic             line_d;

  // Word length is 5 + WLS, so the index of the last data bit is 4 + WLS.
  assign last_bit = {1'b1, wls_q};

  always_comb begin
    tick_last = LastOne;
    if (state_q == StStop && stb_q) begin
      tick_last = (wls_q == 2'b00) ? LastOneHalf : LastTwo;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    eps_d   = eps_q;
    sp_d    = sp_q;

    if (state_q == StIdle) begin
      // TXCLK is not needed to accept a character.
      if (TXSTART) begin
        data_d  = DIN;
        wls_d   = WLS;
        stb_d   = STB;
        pen_d   = PEN;
        eps_d   = EPS;
        sp_d    = SP;
        state_d = StStart;
        tick_d  = '0;
        bit_d   = '0;
      end
    end else if (TXCLK) begin
      if (tick_q == tick_last) begin
        tick_d = '0;
        case (state_q)
          StStart: begin
            state_d = StData;
            bit_d   = '0;
          end
          StData: begin
            if (bit_q == last_bit) begin
              bit_d   = '0;
              state_d = pen_q ? StParity : StStop;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          StParity: state_d = StStop;
          default:  state_d = StIdle;
        endcase
      end else begin
        tick_d = tick_q + TickW'(1);
      end
    end
  end

  // Line value of the bit that will be on the wire after this edge. Derived from the
  // next-state values so SOUT changes on the same edge as the state.
  always_comb begin
    mask_d   = 8'hFF >> (2'd3 - wls_d);
    parity_d = sp_d ? ~eps_d : (eps_d ? ^(data_d & mask_d) : ~^(data_d & mask_d));
    case (state_d)
      StStart:  line_d = 1'b0;
      StData:   line_d = data_d[bit_d];
      StParity: line_d = parity_d;
      default:  line_d = 1'b1;
    endcase
    sout_d = BC ? 1'b0 : line_d;
    fin_d  = (state_d == StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      sp_q    <= 1'b0;
      sout_q  <= 1'b1;
      fin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      sp_q    <= sp_d;
      sout_q  <= sout_d;
      fin_q   <= fin_d;
    end
  end

  assign SOUT       = sout_q;
  assign TXFINISHED = fin_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed testbench for uart_transmitter. Inputs change 1 time unit after a rising edge;
// outputs are sampled at that same point, so sample k reflects the k-th edge after
// character acceptance (edge 0).
module tb_uart_transmitter;

  logic       CLK;
  logic       RST;
  logic       TXCLK;
  logic       TXSTART;
  logic       CLEAR;
  logic [1:0] WLS;
  logic       STB;
  logic       PEN;
  logic       EPS;
  logic       SP;
  logic       BC;
  logic [7:0] DIN;
  logic       TXFINISHED;
  logic       SOUT;

  int checks   = 0;
  int failures = 0;

  // TXCLK pulses every div-th cycle, phase-locked to the most recent TXSTART edge.
  int div   = 1;
  int phase = 0;

  logic wave [0:599];
  logic finw [0:599];

  uart_transmitter #(
    .OVERSAMPLE(16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TXCLK     (TXCLK),
    .TXSTART   (TXSTART),
    .CLEAR     (CLEAR),
    .WLS       (WLS),
    .STB       (STB),
    .PEN       (PEN),
    .EPS       (EPS),
    .SP        (SP),
    .BC        (BC),
    .DIN       (DIN),
    .TXFINISHED(TXFINISHED),
    .SOUT      (SOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) phase <= TXSTART ? 0 : phase + 1;
  assign TXCLK = ((phase % div) == (div - 1));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one character for one cycle; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] w, input logic s,
                      input logic p, input logic e, input logic sp_i);
    DIN = d; WLS = w; STB = s; PEN = p; EPS = e; SP = sp_i;
    TXSTART = 1'b1;
    step();
    TXSTART = 1'b0;
  endtask

  // Record n samples; BC is raised after sample bc_on and dropped after sample bc_off.
  task automatic capture(input int n, input int bc_on, input int bc_off);
    for (int k = 0; k < n; k++) begin
      wave[k] = SOUT;
      finw[k] = TXFINISHED;
      if (k == bc_on) BC = 1'b1;
      if (k == bc_off) BC = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; CLEAR = 1'b0; TXSTART = 1'b0; BC = 1'b0;
    DIN = 8'h00; WLS = 2'b00; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    repeat (3) step();
    checks++;
    if (SOUT !== 1'b1) begin
      failures++; $display("FAIL reset_sout got=%b exp=1", SOUT);
    end
    checks++;
    if (TXFINISHED !== 1'b1) begin
      failures++; $display("FAIL reset_fin got=%b exp=1", TXFINISHED);
    end
    // Reset wins over TXSTART in the same cycle.
    TXSTART = 1'b1;
    step();
    checks++;
    if (SOUT !== 1'b1 || TXFINISHED !== 1'b1) begin
      failures++; $display("FAIL reset_over_start got=%b%b exp=11", SOUT, TXFINISHED);
    end
    TXSTART = 1'b0;
    RST = 1'b0;
    step();
  endtask

  task automatic test_8n1();
    logic [9:0] fr;
    fr  = {1'b1, 8'h55, 1'b0};
    div = 1;
    send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(170, -1, -1);
    checks++;
    if (finw[0] !== 1'b0) begin
      failures++; $display("FAIL 8n1_fin_drop got=%b exp=0", finw[0]);
    end
    for (int j = 0; j < 10; j++) begin
      for (int e = 0; e < 2; e++) begin
        checks++;
        if (wave[16 * j + 15 * e] !== fr[j]) begin
          failures++;
          $display("FAIL 8n1_bit j=%0d k=%0d got=%b exp=%b", j, 16 * j + 15 * e,
                   wave[16 * j + 15 * e], fr[j]);
        end
      end
    end
    checks++;
    if (finw[159] !== 1'b0 || finw[160] !== 1'b1 || wave[160] !== 1'b1) begin
      failures++;
      $display("FAIL 8n1_finish got=%b%b%b exp=011", finw[159], finw[160], wave[160]);
    end
  endtask

  task automatic test_5bit_15stop();
    logic [6:0] fr;
    fr  = {1'b1, 5'h1F, 1'b0};
    div = 4;
    send(8'hFF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    capture(490, -1, -1);
    // One tick every 4 cycles: each bit is 64 cycles, stop 96 cycles.
    for (int j = 0; j < 7; j++) begin
      for (int e = 0; e < 2; e++) begin
        checks++;
        if (wave[64 * j + 63 * e] !== fr[j]) begin
          failures++;
          $display("FAIL w5_bit j=%0d k=%0d got=%b exp=%b", j, 64 * j + 63 * e,
                   wave[64 * j + 63 * e], fr[j]);
        end
      end
    end
    checks++;
    if (finw[479] !== 1'b0) begin
      failures++; $display("FAIL w5_stop_len finw[479] got=%b exp=0", finw[479]);
    end
    checks++;
    if (finw[480] !== 1'b1 || wave[480] !== 1'b1) begin
      failures++; $display("FAIL w5_finish got=%b%b exp=11", finw[480], wave[480]);
    end
    div = 1;
  endtask

  task automatic test_parity();
    logic [3:0] eps_v;
    logic [3:0] sp_v;
    logic [3:0] par_v;
    logic [9:0] fr;
    eps_v = 4'b0101; // case index 0..3: EPS = 1, 0, 1, 0
    sp_v  = 4'b1100; // SP = 0, 0, 1, 1
    par_v = 4'b1001; // parity = 1, 0, 0, 1
    div   = 1;
    for (int c = 0; c < 4; c++) begin
      fr = {1'b1, par_v[c], 7'h07, 1'b0};
      // DIN[7] set but outside a 7-bit word, so it must not affect parity.
      send(8'h87, 2'b10, 1'b0, 1'b1, eps_v[c], sp_v[c]);
      capture(162, -1, -1);
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (wave[16 * j + 8] !== fr[j]) begin
          failures++;
          $display("FAIL parity case=%0d bit=%0d got=%b exp=%b", c, j, wave[16 * j + 8], fr[j]);
        end
      end
      checks++;
      if (finw[159] !== 1'b0 || finw[160] !== 1'b1) begin
        failures++;
        $display("FAIL parity_len case=%0d got=%b%b exp=01", c, finw[159], finw[160]);
      end
    end
  endtask

  task automatic test_abort(input logic use_rst);
    logic [9:0] fr;
    div = 1;
    send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(70, -1, -1); // now inside data bit 3
    checks++;
    if (SOUT !== 1'b0 || TXFINISHED !== 1'b0) begin
      failures++; $display("FAIL abort_pre rst=%b got=%b%b exp=00", use_rst, SOUT, TXFINISHED);
    end
    if (use_rst) RST = 1'b1;
    else CLEAR = 1'b1;
    step();
    checks++;
    if (SOUT !== 1'b1 || TXFINISHED !== 1'b1) begin
      failures++; $display("FAIL abort_post rst=%b got=%b%b exp=11", use_rst, SOUT, TXFINISHED);
    end
    RST = 1'b0;
    CLEAR = 1'b0;
    step();
    fr = {1'b1, 8'hA3, 1'b0};
    send(8'hA3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(162, -1, -1);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (wave[16 * j + 8] !== fr[j]) begin
        failures++;
        $display("FAIL abort_refr rst=%b bit=%0d got=%b exp=%b", use_rst, j, wave[16 * j + 8], fr[j]);
      end
    end
    checks++;
    if (finw[159] !== 1'b0 || finw[160] !== 1'b1) begin
      failures++;
      $display("FAIL abort_refr_len rst=%b got=%b%b exp=01", use_rst, finw[159], finw[160]);
    end
  endtask

  task automatic test_break();
    logic [8:0] k_v [0:7];
    logic       e_v [0:7];
    k_v = '{9'd40, 9'd41, 9'd60, 9'd80, 9'd81, 9'd143, 9'd144, 9'd160};
    e_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    div = 1;
    send(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    capture(162, 40, 80);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wave[k_v[i]] !== e_v[i]) begin
        failures++;
        $display("FAIL break k=%0d got=%b exp=%b", k_v[i], wave[k_v[i]], e_v[i]);
      end
    end
    checks++;
    if (finw[159] !== 1'b0 || finw[160] !== 1'b1) begin
      failures++; $display("FAIL break_timing got=%b%b exp=01", finw[159], finw[160]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fr1;
    logic [10:0] fr2;
    fr1 = {2'b11, 8'h3C, 1'b0};
    fr2 = {2'b11, 8'hC5, 1'b0};
    div = 1;
    DIN = 8'h3C; WLS = 2'b11; STB = 1'b1; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    TXSTART = 1'b1;
    step();
    for (int k = 0; k < 356; k++) begin
      wave[k] = SOUT;
      finw[k] = TXFINISHED;
      if (k == 1) begin
        DIN = 8'hC5;
        WLS = 2'b00; // must not shorten the frame in flight
      end
      if (k == 100) WLS = 2'b11;
      if (k == 300) TXSTART = 1'b0;
      step();
    end
    for (int j = 0; j < 11; j++) begin
      checks++;
      if (wave[16 * j + 8] !== fr1[j]) begin
        failures++;
        $display("FAIL b2b_f1 bit=%0d got=%b exp=%b", j, wave[16 * j + 8], fr1[j]);
      end
      checks++;
      if (wave[177 + 16 * j + 8] !== fr2[j]) begin
        failures++;
        $display("FAIL b2b_f2 bit=%0d got=%b exp=%b", j, wave[177 + 16 * j + 8], fr2[j]);
      end
    end
    checks++;
    if (finw[160] !== 1'b0 || finw[175] !== 1'b0) begin
      failures++; $display("FAIL b2b_2stop got=%b%b exp=00", finw[160], finw[175]);
    end
    checks++;
    if (finw[176] !== 1'b1 || wave[176] !== 1'b1) begin
      failures++; $display("FAIL b2b_gap got=%b%b exp=11", finw[176], wave[176]);
    end
    checks++;
    if (finw[177] !== 1'b0 || wave[177] !== 1'b0) begin
      failures++; $display("FAIL b2b_restart got=%b%b exp=00", finw[177], wave[177]);
    end
    checks++;
    if (finw[352] !== 1'b0 || finw[353] !== 1'b1 || finw[355] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end got=%b%b%b exp=011", finw[352], finw[353], finw[355]);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_5bit_15stop();
    test_parity();
    test_abort(1'b0);
    test_abort(1'b1);
    test_break();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
